// File: rtl/game_pkg.sv
// Shared game constants: state encoding and default screen/sprite geometry
// so the controller and the box/board datapath agree on the same numbers.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    localparam int BOX_W_DEF   = 100;
    localparam int BOX_H_DEF   = 100;
    localparam int BOARD_W_DEF = 100;
    localparam int BOARD_Y_DEF = 400;
    localparam int DRAW_W_DEF  = 640;
    localparam int DRAW_H_DEF  = 480;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse when the debounced (active-low) button becomes pressed.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= 2'b11;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_n};
            r_press <= 1'b0;
            // Any bounce back to the accepted level restarts the stability window.
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                r_cnt    <= '0;
                r_stable <= r_sync[1];
                r_press  <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: idle/serve/play/over FSM, frame-divided move enable,
// paddle-hit scoring and floor-miss life accounting.
module game_ctrl
    import game_pkg::*;
#(
    parameter int FRAME_DIV    = 1,
    parameter int SERVE_FRAMES = 60,
    parameter int LIVES        = 3,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int BOX_W        = BOX_W_DEF,
    parameter int BOX_H        = BOX_H_DEF,
    parameter int BOARD_W      = BOARD_W_DEF,
    parameter int BOARD_Y      = BOARD_Y_DEF,
    parameter int DRAW_H       = DRAW_H_DEF,
    parameter int SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_sync,
    input  logic               button_start,
    input  logic [15:0]        box_x,
    input  logic [15:0]        box_y,
    input  logic [15:0]        board_x,
    output logic               move_en,
    output logic               game_rst_n,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         lives,
    output logic               game_over
);

    localparam int DW = $clog2(FRAME_DIV + 1);
    localparam int SW = $clog2(SERVE_FRAMES + 1);

    game_state_e        r_state, w_nxt_state;
    logic [SCORE_W-1:0] r_score, w_nxt_score;
    logic [3:0]         r_lives, w_nxt_lives;
    logic [DW-1:0]      r_div,   w_nxt_div;
    logic [SW-1:0]      r_serve, w_nxt_serve;
    logic               r_armed, w_nxt_armed;
    logic               r_fs_d,  r_tick;
    logic               w_press, w_move_en;

    logic [16:0] w_box_bot, w_box_right, w_board_right;
    logic        w_miss, w_overlap, w_low;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (button_start),
        .press (w_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fs_d <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_fs_d <= frame_sync;
            r_tick <= frame_sync & ~r_fs_d;
        end
    end

    // 17-bit sums so coordinates near 16'hFFFF cannot wrap into a false hit.
    assign w_box_bot     = {1'b0, box_y}   + 17'(BOX_H);
    assign w_box_right   = {1'b0, box_x}   + 17'(BOX_W);
    assign w_board_right = {1'b0, board_x} + 17'(BOARD_W);
    assign w_miss        = w_box_bot >= 17'(DRAW_H);
    assign w_overlap     = (w_box_right > {1'b0, board_x}) && ({1'b0, box_x} < w_board_right);
    assign w_low         = w_box_bot >= 17'(BOARD_Y);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_score = r_score;
        w_nxt_lives = r_lives;
        w_nxt_div   = r_div;
        w_nxt_serve = r_serve;
        w_nxt_armed = r_armed;
        w_move_en   = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (w_press) begin
                    w_nxt_state = ST_SERVE;
                    w_nxt_score = '0;
                    w_nxt_lives = 4'(LIVES);
                    w_nxt_serve = '0;
                    w_nxt_div   = '0;
                end
            end
            ST_SERVE: begin
                if (r_tick) begin
                    if (r_serve == SW'(SERVE_FRAMES - 1)) begin
                        w_nxt_state = ST_PLAY;
                        w_nxt_serve = '0;
                        w_nxt_div   = '0;
                        w_nxt_armed = 1'b1;
                    end else begin
                        w_nxt_serve = r_serve + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (r_tick) begin
                    if (w_miss) begin
                        w_nxt_serve = '0;
                        w_nxt_div   = '0;
                        if (r_lives > 4'd1) begin
                            w_nxt_lives = r_lives - 1'b1;
                            w_nxt_state = ST_SERVE;
                        end else begin
                            w_nxt_lives = '0;
                            w_nxt_state = ST_OVER;
                        end
                    end else begin
                        if (r_div == DW'(FRAME_DIV - 1)) begin
                            w_move_en = 1'b1;
                            w_nxt_div = '0;
                        end else begin
                            w_nxt_div = r_div + 1'b1;
                        end
                        if (r_armed && w_overlap && w_low) begin
                            w_nxt_armed = 1'b0;
                            if (r_score != {SCORE_W{1'b1}})
                                w_nxt_score = r_score + 1'b1;
                        end
                        if (!w_low)
                            w_nxt_armed = 1'b1;
                    end
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_score <= '0;
            r_lives <= 4'(LIVES);
            r_div   <= '0;
            r_serve <= '0;
            r_armed <= 1'b1;
        end else begin
            r_state <= w_nxt_state;
            r_score <= w_nxt_score;
            r_lives <= w_nxt_lives;
            r_div   <= w_nxt_div;
            r_serve <= w_nxt_serve;
            r_armed <= w_nxt_armed;
        end
    end

    assign move_en    = w_move_en;
    assign state      = r_state;
    assign score      = r_score;
    assign lives      = r_lives;
    assign game_over  = (r_state == ST_OVER);
    assign game_rst_n = (r_state == ST_PLAY) || (r_state == ST_OVER);

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed game scenarios followed by
// randomized frames, compared against a per-frame behavioural game model.
module tb_game_ctrl;

    localparam int FD = 3, SF = 2, LV = 3, DB = 4, SCW = 3;
    localparam int SMAX = (1 << SCW) - 1;

    logic           clk = 1'b0, rst_n = 1'b0, frame_sync = 1'b0, button_start = 1'b1;
    logic [15:0]    box_x = '0, box_y = '0, board_x = '0;
    logic           move_en, game_rst_n, game_over;
    logic [1:0]     state;
    logic [SCW-1:0] score;
    logic [3:0]     lives;

    int n_chk = 0, n_pass = 0, me_cnt = 0;
    int m_state, m_score, m_lives, m_div, m_serve, m_me_cnt;
    bit m_armed;

    game_ctrl #(
        .FRAME_DIV(FD), .SERVE_FRAMES(SF), .LIVES(LV), .DEBOUNCE_CYC(DB), .SCORE_W(SCW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_sync(frame_sync), .button_start(button_start),
        .box_x(box_x), .box_y(box_y), .board_x(board_x), .move_en(move_en),
        .game_rst_n(game_rst_n), .state(state), .score(score), .lives(lives),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (move_en === 1'b1) me_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // States: 0 idle, 1 serve, 2 play, 3 over.
    task automatic model_reset();
        m_state = 0; m_score = 0; m_lives = LV; m_div = 0; m_serve = 0; m_armed = 1;
    endtask

    task automatic model_press();
        if (m_state == 0 || m_state == 3) begin
            m_state = 1; m_score = 0; m_lives = LV; m_serve = 0; m_div = 0;
        end
    endtask

    task automatic model_tick(input int bx, input int by, input int bdx, output bit me);
        int bot;
        bit miss, ovl;
        me  = 0;
        bot = by + 100;
        miss = bot >= 480;
        ovl  = (bx + 100 > bdx) && (bx < bdx + 100);
        if (m_state == 1) begin
            m_serve++;
            if (m_serve == SF) begin
                m_state = 2; m_serve = 0; m_div = 0; m_armed = 1;
            end
        end else if (m_state == 2) begin
            if (miss) begin
                m_lives--;
                m_state = (m_lives == 0) ? 3 : 1;
                m_serve = 0; m_div = 0;
            end else begin
                m_div++;
                if (m_div == FD) begin me = 1; m_div = 0; end
                if (m_armed && ovl && bot >= 400) begin
                    m_armed = 0;
                    if (m_score < SMAX) m_score++;
                end
                if (bot < 400) m_armed = 1;
            end
        end
        if (me) m_me_cnt++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(m_state));
        chk({tag, ".score"}, 32'(score), 32'(m_score));
        chk({tag, ".lives"}, 32'(lives), 32'(m_lives));
        chk({tag, ".over"}, 32'(game_over), 32'(m_state == 3));
        chk({tag, ".grst"}, 32'(game_rst_n), 32'(m_state >= 2));
        chk({tag, ".mecnt"}, 32'(me_cnt), 32'(m_me_cnt));
    endtask

    task automatic frame(input int bx, input int by, input int bdx);
        bit me;
        @(negedge clk);
        box_x = 16'(bx); box_y = 16'(by); board_x = 16'(bdx);
        frame_sync = 1'b1;
        @(negedge clk);
        model_tick(bx, by, bdx, me);
        chk("tick_move_en", 32'(move_en), 32'(me));
        @(negedge clk);
        frame_sync = 1'b0;
        chk("move_en_width", 32'(move_en), 0);
        repeat (2) @(negedge clk);
        check_all("frame");
    endtask

    task automatic press_btn();
        @(negedge clk);
        button_start = 1'b0;
        repeat (10 * DB) @(negedge clk);
        button_start = 1'b1;
        repeat (10 * DB) @(negedge clk);
        model_press();
        check_all("press");
    endtask

    initial begin
        int base;
        model_reset();
        m_me_cnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_grst", 32'(game_rst_n), 0);
        chk("rst_move_en", 32'(move_en), 0);
        chk("rst_lives", 32'(lives), 3);
        chk("rst_score", 32'(score), 0);
        chk("rst_over", 32'(game_over), 0);
        rst_n = 1'b1;

        repeat (5) frame(0, 0, 400);
        chk("idle_state", 32'(state), 0);
        chk("idle_no_move", 32'(me_cnt), 0);

        press_btn();
        chk("serve_entry", 32'(state), 1);
        frame(0, 0, 400);
        chk("serve_hold", 32'(state), 1);
        chk("serve_grst", 32'(game_rst_n), 0);
        frame(0, 0, 400);
        chk("play_entry", 32'(state), 2);
        chk("play_grst", 32'(game_rst_n), 1);

        base = me_cnt;
        repeat (9) frame(0, 0, 400);
        chk("div_pulses", 32'(me_cnt - base), 3);

        repeat (4) frame(100, 300, 150);
        chk("hit_once", 32'(score), 1);
        frame(100, 250, 150);
        frame(100, 300, 150);
        chk("hit_rearm", 32'(score), 2);

        frame(0, 380, 500);
        chk("miss1_lives", 32'(lives), 2);
        chk("miss1_state", 32'(state), 1);
        repeat (2) frame(0, 0, 500);
        frame(100, 380, 150);
        chk("miss_over_hit_score", 32'(score), 2);
        chk("miss2_lives", 32'(lives), 1);
        repeat (2) frame(0, 0, 500);
        frame(0, 380, 500);
        chk("over_state", 32'(state), 3);
        chk("over_lives", 32'(lives), 0);
        chk("over_flag", 32'(game_over), 1);
        frame(0, 0, 500);
        chk("over_hold", 32'(state), 3);

        press_btn();
        chk("restart_lives", 32'(lives), 3);
        chk("restart_score", 32'(score), 0);
        repeat (2) frame(0, 0, 500);
        frame(100, 300, 150);
        chk("pre_rst_score", 32'(score), 1);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_score", 32'(score), 0);
        chk("arst_lives", 32'(lives), 3);
        chk("arst_grst", 32'(game_rst_n), 0);
        chk("arst_move_en", 32'(move_en), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        press_btn();
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0 || (m_state != 1 && m_state != 2 && $urandom_range(0, 3) == 0))
                press_btn();
            else
                frame(int'($urandom_range(0, 600)), int'($urandom_range(200, 390)),
                      int'($urandom_range(0, 600)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Game sequencer for the bouncing-box / paddle datapath. It owns the game state (idle, serve, play, over) and holds the datapath in soft reset while serving. It issues one movement-step enable per configured number of video frames. It also detects paddle hits and floor misses from the datapath's box/board coordinates to keep score and lives. It sits between the VGA timing generator (frame sync), the pushbuttons and the box/board datapath.

Parameters:
FRAME_DIV, 1, frames per movement step (1..255)
SERVE_FRAMES, 60, frames the datapath is held in reset before play resumes
LIVES, 3, lives loaded at game start (1..15)
DEBOUNCE_CYC, 250000, clk cycles the start button must be stable
BOX_W, 100, box width in pixels
BOX_H, 100, box height in pixels
BOARD_W, 100, paddle width in pixels
BOARD_Y, 400, paddle top row
DRAW_H, 480, drawable height
SCORE_W, 8, score counter width

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  reset, asynchronous, active-low
frame_sync  in  1  level high during vertical blank, synchronous to clk; rising edge = new frame
button_start  in  1  raw pushbutton, active-low
box_x  in  16  current box left column
box_y  in  16  current box top row
board_x  in  16  current paddle left column
move_en  out  1  one-cycle step enable to datapath
game_rst_n  out  1  active-low soft reset to datapath
state  out  2  0=IDLE 1=SERVE 2=PLAY 3=OVER
score  out  SCORE_W  hits this game, saturating
lives  out  4  remaining lives
game_over  out  1  high in OVER

Behaviour:
- Reset values: state=IDLE, move_en=0, game_rst_n=0, score=0, lives=LIVES, game_over=0, all counters 0, hit_armed=1.
- Reset applied mid-game returns everything to the reset values immediately (asynchronous); no partial state survives.
- frame_tick: one-cycle internal pulse on the rising edge of frame_sync (registered compare, 1-cycle latency). It is never asserted in the reset cycle.
- start_press: one-cycle pulse from the debouncer when button_start goes to a stable low. Holding the button yields exactly one pulse.
- IDLE:
  - game_rst_n=0, move_en=0.
  - On start_press: score<=0, lives<=LIVES, go to SERVE.
- SERVE:
  - game_rst_n=0.
  - Frame counter increments per frame_tick; on the tick at which it reaches SERVE_FRAMES, clear it, set hit_armed=1 and go to PLAY.
  - start_press is ignored.
- PLAY:
  - game_rst_n=1.
  - Divider counts frame_ticks; on every FRAME_DIV-th tick, move_en=1 for exactly that cycle.
  - With FRAME_DIV=1, move_en is high on the same cycle as each frame_tick.
- Hit and miss evaluation in PLAY, on each frame_tick, using the inputs as sampled that cycle. All sums use 17-bit arithmetic, with no wrap.
  - miss = box_y+BOX_H >= DRAW_H.
  - overlap = box_x+BOX_W > board_x AND box_x < board_x+BOARD_W.
  - hit = hit_armed AND overlap AND box_y+BOX_H >= BOARD_Y.
- Priority: miss over hit; only one of the two acts per tick.
  - Miss with lives>1: lives-1, go to SERVE, suppress move_en that cycle.
  - Miss with lives==1: lives<=0, go to OVER, suppress move_en that cycle.
  - Hit: score+1, saturating at all-ones; hit_armed<=0.
  - hit_armed<=1 on any tick where box_y+BOX_H < BOARD_Y, so each descent scores at most once.
- OVER:
  - game_over=1, move_en=0, game_rst_n=1 (last frame stays visible).
  - Score and lives are held.
  - On start_press: go to SERVE with score<=0, lives<=LIVES.
- game_over is low in all other states.
- start_press in PLAY is ignored.
- A frame_tick and a start_press in the same cycle in IDLE/OVER: the transition happens and the tick is not counted toward SERVE.
- Counter widths are sized by $clog2 of their parameter. The divider and serve counters are cleared on every state entry.

Decomposition:
- Shared package game_pkg: state encoding constants (ST_IDLE, ST_SERVE, ST_PLAY, ST_OVER) and geometry defaults (BOX_W/H, BOARD_W, BOARD_Y, DRAW_W/H), so the datapath and controller agree.
- One sub-module, btn_debounce: 2-flop synchroniser, stable counter and falling-edge one-shot. Parameter DEBOUNCE_CYC; ports clk, rst_n, btn_n, press.

Test Plan:
- Reset then idle, 5 frames -> state=0, game_rst_n=0, move_en never high, lives=3, score=0.
- button_start held low 10 debounce periods (DEBOUNCE_CYC=4 in bench), SERVE_FRAMES=2 -> exactly one transition to SERVE, PLAY after 2 frame ticks, game_rst_n rises on entry to PLAY.
- PLAY with FRAME_DIV=3, 9 frames, box far from floor -> exactly 3 move_en pulses, each 1 cycle, on ticks 3, 6, 9.
- box_y=300, box_x=100, board_x=150 held for 4 ticks -> score=1 only; then box_y=250 for one tick, box_y=300 again -> score=2.
- box_y=380, board far away, lives=3 -> lives=2, state=SERVE, no move_en that tick. Repeat twice -> lives=0, state=OVER, game_over=1. start_press -> SERVE, lives=3, score=0.
- Same tick with miss and hit conditions both true (box_y=380 over paddle) -> miss wins, score unchanged. rst_n low mid-PLAY -> all outputs at reset values immediately, without waiting for a clk edge.
